pixel_plot_receiver: RTL and testbench



---
 rtl/pixel_plot_receiver.sv | 163 ++++++++++++++++
 tb/tb_pixel_plot_receiver.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pixel_plot_receiver.sv
// pixel_plot_receiver
//   Receiving end of the pixel-plot interface. Plot requests are
//   bounds-checked and then queued in a small FIFO. Each queued pixel is
//   turned into a linear framebuffer address (y*WIDTH+x) and written
//   through a ready/valid holding register. The block also runs a
//   full-screen clear when asked.
//
// Ports
//   clock, reset         : system clock; synchronous active-high reset
//   plot, x, y, colour   : plot request, one pixel per high cycle
//   clearScreen          : clear request pulse
//   clearColour          : fill colour, sampled together with clearScreen
//   memReady             : framebuffer accepts the presented write
//   memAddress/memData/memWren : framebuffer write port (holding register)
//   busy                 : work outstanding (not IDLE, FIFO non-empty, clear pending)
//   clearDone            : one-cycle pulse when the clear finishes
//   dropCount, oobCount  : saturating counts of refused and out-of-bounds plots
module pixel_plot_receiver #(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  plot,
  input  logic [8:0]            x,
  input  logic [7:0]            y,
  input  logic [2:0]            colour,
  input  logic                  clearScreen,
  input  logic [2:0]            clearColour,
  input  logic                  memReady,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic [2:0]            memData,
  output logic                  memWren,
  output logic                  busy,
  output logic                  clearDone,
  output logic [7:0]            dropCount,
  output logic [7:0]            oobCount
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LAST  = WIDTH * HEIGHT - 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  logic [0:0]            r_state;
  logic [19:0]           r_fifo [FIFO_DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0]        r_wptr, r_rptr;
  logic                  r_clrPend;
  logic [2:0]            r_clrCol;
  logic [ADDR_WIDTH-1:0] r_memAddr;
  logic [2:0]            r_memData;
  logic                  r_memWren;
  logic                  r_clearDone;
  logic [7:0]            r_drop, r_oob;

  logic                  w_empty, w_full, w_oob, w_drop, w_push, w_free, w_pop;
  logic [19:0]           w_head;
  logic [8:0]            w_hx;
  logic [7:0]            w_hy;
  logic [2:0]            w_hcol;
  logic [ADDR_WIDTH-1:0] w_addr;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                   (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);

  // Out-of-bounds wins over the drop check. r_clrPend stays high for the
  // whole clear, so it covers both "pending" and "active".
  assign w_oob  = plot && ((32'(x) >= WIDTH) || (32'(y) >= HEIGHT));
  assign w_drop = plot && !w_oob && (w_full || r_clrPend);
  assign w_push = plot && !w_oob && !w_full && !r_clrPend;

  // The output register can take new data if it is empty or draining this edge.
  assign w_free = !r_memWren || memReady;
  assign w_pop  = (r_state == S_IDLE) && !w_empty && w_free;

  assign w_head = r_fifo[r_rptr[PTR_W-1:0]];
  assign w_hx   = w_head[19:11];
  assign w_hy   = w_head[10:3];
  assign w_hcol = w_head[2:0];
  assign w_addr = ADDR_WIDTH'(w_hy) * ADDR_WIDTH'(WIDTH) + ADDR_WIDTH'(w_hx);

  // FIFO storage is not reset; the pointers alone define its contents.
  always_ff @(posedge clock) begin
    if (w_push) r_fifo[r_wptr[PTR_W-1:0]] <= {x, y, colour};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_clrPend   <= 1'b0;
      r_clrCol    <= 3'd0;
      r_memAddr   <= '0;
      r_memData   <= 3'd0;
      r_memWren   <= 1'b0;
      r_clearDone <= 1'b0;
      r_drop      <= 8'd0;
      r_oob       <= 8'd0;
    end else begin
      r_clearDone <= 1'b0;
      if (w_oob  && (r_oob  != 8'hFF)) r_oob  <= r_oob  + 8'd1;
      if (w_drop && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
      if (w_push) r_wptr <= r_wptr + 1'b1;

      // A request while a clear is pending or running is ignored outright.
      if (clearScreen && !r_clrPend) begin
        r_clrPend <= 1'b1;
        r_clrCol  <= clearColour;
      end

      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_memAddr <= w_addr;
            r_memData <= w_hcol;
            r_memWren <= 1'b1;
            r_rptr    <= r_rptr + 1'b1;
          end else if (w_free) begin
            // Queued plots drain first; the clear starts only once the
            // FIFO is empty and the last pixel write is leaving.
            if (r_clrPend) begin
              r_state   <= S_CLEAR;
              r_memAddr <= '0;
              r_memData <= r_clrCol;
              r_memWren <= 1'b1;
            end else begin
              r_memWren <= 1'b0;
            end
          end
        end
        S_CLEAR: begin
          // memAddress doubles as the clear counter.
          if (r_memWren && memReady) begin
            if (r_memAddr == ADDR_WIDTH'(LAST)) begin
              r_memWren   <= 1'b0;
              r_clearDone <= 1'b1;
              r_clrPend   <= 1'b0;
              r_state     <= S_IDLE;
            end else begin
              r_memAddr <= r_memAddr + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign memAddress = r_memAddr;
  assign memData    = r_memData;
  assign memWren    = r_memWren;
  assign clearDone  = r_clearDone;
  assign dropCount  = r_drop;
  assign oobCount   = r_oob;
  assign busy       = (r_state != S_IDLE) || !w_empty || r_clrPend;

endmodule

// File: tb/tb_pixel_plot_receiver.sv
// Directed bench for pixel_plot_receiver: reset state, plot latency,
// bounds checks, backpressure/FIFO full, clear sequencing, reset during
// clear and counter saturation.
module tb_pixel_plot_receiver;

  logic        clock = 1'b0;
  logic        reset;
  logic        plot;
  logic [8:0]  x;
  logic [7:0]  y;
  logic [2:0]  colour;
  logic        clearScreen;
  logic [2:0]  clearColour;
  logic        memReady;
  logic [16:0] memAddress;
  logic [2:0]  memData;
  logic        memWren;
  logic        busy;
  logic        clearDone;
  logic [7:0]  dropCount;
  logic [7:0]  oobCount;

  int n_cmp  = 0;
  int n_fail = 0;

  pixel_plot_receiver dut (
    .clock(clock), .reset(reset), .plot(plot), .x(x), .y(y), .colour(colour),
    .clearScreen(clearScreen), .clearColour(clearColour), .memReady(memReady),
    .memAddress(memAddress), .memData(memData), .memWren(memWren), .busy(busy),
    .clearDone(clearDone), .dropCount(dropCount), .oobCount(oobCount)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  int cnt, bad;
  logic seen;

  initial begin
    reset = 1'b1; plot = 1'b0; x = '0; y = '0; colour = '0;
    clearScreen = 1'b0; clearColour = '0; memReady = 1'b1;
    tick; tick;
    check("rst_wren", memWren, 0);
    check("rst_addr", memAddress, 0);
    check("rst_data", memData, 0);
    check("rst_done", clearDone, 0);
    check("rst_drop", dropCount, 0);
    check("rst_oob",  oobCount, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    tick;

    // Single plot: write appears after the second edge, for one cycle.
    plot = 1'b1; x = 9'd5; y = 8'd2; colour = 3'b101;
    tick;
    plot = 1'b0;
    check("lat_e0_wren", memWren, 0);
    tick;
    check("lat_e1_wren", memWren, 1);
    check("lat_addr", memAddress, 645);
    check("lat_data", memData, 5);
    tick;
    check("lat_e2_wren", memWren, 0);

    // Out-of-bounds on each axis, then the farthest in-range corner.
    plot = 1'b1; x = 9'd320; y = 8'd0;
    tick;
    x = 9'd0; y = 8'd240;
    tick;
    plot = 1'b0;
    tick;
    check("oob_wren", memWren, 0);
    check("oob_count", oobCount, 2);
    check("oob_drop", dropCount, 0);
    plot = 1'b1; x = 9'd319; y = 8'd239; colour = 3'd6;
    tick;
    plot = 1'b0;
    tick;
    check("corner_wren", memWren, 1);
    check("corner_addr", memAddress, 76799);
    check("corner_data", memData, 6);
    tick;
    check("corner_idle", memWren, 0);

    // Backpressure: 1 held + 8 queued, the 10th is dropped.
    memReady = 1'b0;
    for (int i = 0; i < 10; i++) begin
      plot = 1'b1; x = 9'(i); y = 8'd1; colour = 3'(i);
      tick;
    end
    plot = 1'b0;
    check("bp_drop", dropCount, 1);
    check("bp_busy", busy, 1);
    tick;
    check("bp_hold_wren", memWren, 1);
    check("bp_hold_addr", memAddress, 320);
    memReady = 1'b1;
    bad = 0;
    for (int k = 0; k < 9; k++) begin
      if (!(memWren === 1'b1 && memAddress == 17'(320 + k) && memData == 3'(k))) bad++;
      tick;
    end
    check("bp_drain_bad", bad, 0);
    check("bp_drain_end", memWren, 0);

    // Three plots, then a clear: pixels first, then the full clear.
    plot = 1'b1; x = 9'd10; y = 8'd0; colour = 3'd7;
    tick;
    x = 9'd11;
    tick;
    check("clr_px0", memAddress, 10);
    x = 9'd12;
    tick;
    check("clr_px1", memAddress, 11);
    plot = 1'b0; clearScreen = 1'b1; clearColour = 3'd0;
    tick;
    clearScreen = 1'b0;
    check("clr_px2", memAddress, 12);
    check("clr_px2_data", memData, 7);
    check("clr_busy", busy, 1);
    cnt = 0; bad = 0; seen = 1'b0;
    for (int i = 0; i < 77000; i++) begin
      plot = (i == 100); x = 9'd2; y = 8'd2;
      tick;
      if (clearDone) begin seen = 1'b1; break; end
      if (!(memWren === 1'b1 && memAddress == 17'(cnt) && memData == 3'd0)) bad++;
      cnt++;
    end
    plot = 1'b0;
    check("clr_done_seen", seen, 1);
    check("clr_count", cnt, 76800);
    check("clr_bad", bad, 0);
    check("clr_end_wren", memWren, 0);
    check("clr_end_busy", busy, 0);
    check("clr_drop", dropCount, 2);
    tick;
    check("clr_done_pulse", clearDone, 0);

    // Reset in the middle of a clear; a second request must not relatch colour.
    clearScreen = 1'b1; clearColour = 3'd3;
    tick;
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      clearScreen = (i == 50); clearColour = 3'd1;
      tick;
      if (memWren && memAddress == 17'd1000) begin seen = 1'b1; break; end
    end
    clearScreen = 1'b0;
    check("mid_reached", seen, 1);
    check("mid_colour", memData, 3);
    reset = 1'b1;
    tick;
    check("mid_rst_wren", memWren, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_drop", dropCount, 0);
    check("mid_rst_oob", oobCount, 0);
    check("mid_rst_addr", memAddress, 0);
    reset = 1'b0;
    plot = 1'b1; x = 9'd0; y = 8'd0; colour = 3'd6;
    tick;
    plot = 1'b0;
    tick;
    check("post_wren", memWren, 1);
    check("post_addr", memAddress, 0);
    check("post_data", memData, 6);
    tick;
    check("post_idle", memWren, 0);

    // Saturation of the out-of-bounds counter.
    for (int i = 0; i < 300; i++) begin
      plot = 1'b1; x = 9'd400; y = 8'd0;
      tick;
    end
    plot = 1'b0;
    tick;
    check("sat_oob", oobCount, 255);
    check("sat_drop", dropCount, 0);
    check("sat_wren", memWren, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
